// File: rtl/cp0_tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_tlb_op_ctrl
//
// Sequencer between the CP0/execute stage and the TLB maintenance port.
// It accepts one TLBP/TLBR/TLBWI/TLBWR at a time and freezes the CP0 operands.
// It presents a registered request to the TLB until tlb_ok comes back.
// It then issues a single-cycle CP0 writeback together with a done pulse.
// The block also owns the CP0 Random register that TLBWR uses as its target.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   op_valid, op_code      TLB instruction from the issuing stage
//                          (0=TLBP 1=TLBR 2=TLBWI 3=TLBWR)
//   cp0_*                  live CP0 EntryHi/EntryLo0/EntryLo1/Index/Wired
//   wired_we               CP0 Wired is being written (reloads Random)
//   tlb_req, tlb_*         request code (0=none, 1..4 = op+1) and latched operands
//   tlb_ok, res_*          TLB completion and result data
//   stall, done            pipeline hold and one-cycle completion pulse
//   wb_index_we, wb_index  Index writeback (TLBP)
//   wb_read_we, wb_entry*  EntryHi/EntryLo0/EntryLo1 writeback (TLBR)
//   random                 CP0 Random
// -----------------------------------------------------------------------------
module cp0_tlb_op_ctrl #(
    parameter int TLBEntries = 32,
    parameter int IDX_W      = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic [31:0]       cp0_entryhi,
    input  logic [31:0]       cp0_entrylo0,
    input  logic [31:0]       cp0_entrylo1,
    input  logic [31:0]       cp0_index,
    input  logic [IDX_W-1:0]  cp0_wired,
    input  logic              wired_we,
    output logic [2:0]        tlb_req,
    output logic [31:0]       tlb_entryhi,
    output logic [31:0]       tlb_entrylo0,
    output logic [31:0]       tlb_entrylo1,
    output logic [31:0]       tlb_index,
    input  logic              tlb_ok,
    input  logic [31:0]       res_index,
    input  logic [31:0]       res_entryhi,
    input  logic [31:0]       res_entrylo0,
    input  logic [31:0]       res_entrylo1,
    output logic              stall,
    output logic              done,
    output logic              wb_index_we,
    output logic [31:0]       wb_index,
    output logic              wb_read_we,
    output logic [31:0]       wb_entryhi,
    output logic [31:0]       wb_entrylo0,
    output logic [31:0]       wb_entrylo1,
    output logic [IDX_W-1:0]  random
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    localparam logic [IDX_W-1:0] RANDOM_MAX  = IDX_W'(TLBEntries - 1);
    // One extra bit so a Wired value equal to TLBEntries is still detectable.
    localparam logic [IDX_W:0]   ENTRIES_EXT = (IDX_W + 1)'(TLBEntries);

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic             accept;
    logic [IDX_W-1:0] random_next;

    assign accept = (state == S_IDLE) && op_valid;

    // The instruction is held from the cycle it is presented until the TLB
    // answers; the writeback cycle is already free so it retires with done.
    assign stall = accept || (state == S_REQ);

    // Random reload takes priority over the decrement. An out-of-range Wired
    // value pins Random at the top entry instead of letting it wander.
    always_comb begin
        random_next = random - IDX_W'(1);
        if (wired_we || ({1'b0, cp0_wired} >= ENTRIES_EXT) ||
            (random == cp0_wired) || (random == '0)) begin
            random_next = RANDOM_MAX;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random <= RANDOM_MAX;
        end else begin
            random <= random_next;
        end
    end

    // Operation sequencer. Writeback strobes and done default low every cycle
    // so that they can only ever be one cycle wide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            op_q         <= 2'd0;
            tlb_req      <= 3'd0;
            tlb_entryhi  <= 32'd0;
            tlb_entrylo0 <= 32'd0;
            tlb_entrylo1 <= 32'd0;
            tlb_index    <= 32'd0;
            done         <= 1'b0;
            wb_index_we  <= 1'b0;
            wb_index     <= 32'd0;
            wb_read_we   <= 1'b0;
            wb_entryhi   <= 32'd0;
            wb_entrylo0  <= 32'd0;
            wb_entrylo1  <= 32'd0;
        end else begin
            done        <= 1'b0;
            wb_index_we <= 1'b0;
            wb_read_we  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q         <= op_code;
                        tlb_entryhi  <= cp0_entryhi;
                        tlb_entrylo0 <= cp0_entrylo0;
                        tlb_entrylo1 <= cp0_entrylo1;
                        // TLBWR targets the Random value current at acceptance.
                        tlb_index    <= (op_code == OP_TLBWR) ?
                                        {{(32 - IDX_W){1'b0}}, random} : cp0_index;
                        tlb_req      <= {1'b0, op_code} + 3'd1;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tlb_ok) begin
                        tlb_req <= 3'd0;
                        done    <= 1'b1;
                        if (op_q == OP_TLBP) begin
                            wb_index_we <= 1'b1;
                            wb_index    <= res_index;
                        end
                        if (op_q == OP_TLBR) begin
                            wb_read_we  <= 1'b1;
                            wb_entryhi  <= res_entryhi;
                            wb_entrylo0 <= res_entrylo0;
                            wb_entrylo1 <= res_entrylo1;
                        end
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    tlb_req <= 3'd0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cp0_tlb_op_ctrl.md
Name: cp0_tlb_op_ctrl

Overview:
Sequencer that sits directly upstream of the TLB's maintenance port. It accepts TLBP/TLBR/TLBWI/TLBWR from the CP0/execute stage and stalls the pipeline while the operation runs. It drives the TLB request with latched CP0 operands and holds it until the TLB returns tlb_ok. It then issues a one-cycle CP0 writeback of the result, and it owns the CP0 Random register used by TLBWR.

Parameters:
TLBEntries, 32, number of TLB entries; Random counts within [wired, TLBEntries-1]
IDX_W, 5, index width, equal to clog2(TLBEntries)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  TLB instruction present in the issuing stage
op_code  in  2  0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
cp0_entryhi  in  32  current CP0 EntryHi
cp0_entrylo0  in  32  current CP0 EntryLo0
cp0_entrylo1  in  32  current CP0 EntryLo1
cp0_index  in  32  current CP0 Index
cp0_wired  in  IDX_W  current CP0 Wired
wired_we  in  1  CP0 Wired is written this cycle
tlb_req  out  3  0=NO_REQ 1=TLBP 2=TLBR 3=TLBWI 4=TLBWR
tlb_entryhi  out  32  latched EntryHi operand
tlb_entrylo0  out  32  latched EntryLo0 operand
tlb_entrylo1  out  32  latched EntryLo1 operand
tlb_index  out  32  target index; for TLBWR this is the latched Random value, zero-extended
tlb_ok  in  1  TLB has completed the current request
res_index  in  32  probe result; bit31=1 means miss
res_entryhi  in  32  TLBR result
res_entrylo0  in  32  TLBR result
res_entrylo1  in  32  TLBR result
stall  out  1  hold the pipeline
done  out  1  one-cycle completion pulse
wb_index_we  out  1  write wb_index into CP0 Index
wb_index  out  32  Index writeback value
wb_read_we  out  1  write EntryHi, EntryLo0, EntryLo1 and PageMask
wb_entryhi  out  32  EntryHi writeback value
wb_entrylo0  out  32  EntryLo0 writeback value
wb_entrylo1  out  32  EntryLo1 writeback value
random  out  IDX_W  CP0 Random

Behaviour:
- Reset (async, resetn=0): state=IDLE, tlb_req=0, stall=0, done=0, all *_we=0, all wb_* and tlb_* data outputs=0, random=TLBEntries-1.
- FSM states: IDLE, REQ, WB.
- IDLE: if op_valid=1 at a clock edge:
  - latch op_code and all cp0_* operands;
  - latch index = (op_code==TLBWR) ? random : cp0_index;
  - go to REQ.
- REQ:
  - tlb_req is registered from the latched op and stays constant until tlb_ok=1 is sampled; then go to WB.
  - No timeout.
  - tlb_ok while in IDLE or WB is ignored.
- WB: lasts exactly one cycle. tlb_req=0, done=1, then return to IDLE.
  - TLBP: wb_index_we=1, wb_index=res_index as captured on the tlb_ok cycle.
  - TLBR: wb_read_we=1; wb_entryhi/wb_entrylo0/wb_entrylo1 = res_* as captured on the tlb_ok cycle. PageMask is written as 0 by CP0.
  - TLBWI/TLBWR: no *_we asserted; done only.
- stall: combinational, equal to (state==IDLE && op_valid) || state==REQ. It deasserts in the WB cycle, so the instruction retires with done.
- Minimum latency: accept at edge N, tlb_req visible N..N+1, tlb_ok at N+1, WB/done at N+2.
- A new op_valid during REQ or WB is not accepted. op_valid presented in the WB cycle is accepted only on the following IDLE cycle.
- Operands are frozen after acceptance. CP0 register changes during REQ do not affect tlb_* outputs.
- Random register:
  - Decrements by 1 every cycle.
  - When random==cp0_wired, or random==0, the next value is TLBEntries-1 (wrap).
  - wired_we=1 forces random=TLBEntries-1 on the next edge; this has priority over decrement.
  - If cp0_wired >= TLBEntries, random is held at TLBEntries-1.
  - random keeps counting while the FSM is busy; only the value latched at acceptance is used.
- Reset mid-operation: immediate return to IDLE, tlb_req=0. No writeback occurs and no done is emitted.
- Width rules:
  - tlb_index is the latched index; the upper bits of cp0_index pass through (the TLB ignores bits above IDX_W).
  - For TLBWR, tlb_index = {zeros, latched random}.

Test Plan:
- TLBP hit: EntryHi=0x0040_2005, op_valid with op_code=0 at N; TLB answers tlb_ok at N+3 with res_index=7 -> tlb_req=1 over N+1..N+3, done and wb_index_we at N+4 with wb_index=7, stall high N..N+3.
- TLBP miss: res_index=0x8000_0000 -> wb_index=0x8000_0000, wb_read_we=0.
- TLBR index 3: res_entrylo0=0x0000_1F1F -> wb_read_we=1, wb_entrylo0=0x0000_1F1F, tlb_req=2 held until tlb_ok.
- TLBWR with wired=4: observe random 31,30,...,4,31; issue op when random=9 -> tlb_index=9 and tlb_req=4 held even though random keeps decrementing; wired_we pulse -> random=31 next cycle.
- TLBWI with cp0_index changed to 12 during REQ -> tlb_index stays at the accepted value 5; done pulse with no *_we.
- Reset asserted in REQ -> tlb_req=0, stall=0, no done; a fresh op after reset completes normally.
